// File: rtl/dstate_wr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dstate_wr_ctrl                                                |
// | Purpose  : Write-side controller for the backprop dstate ping-pong       |
// |            buffer. Accepts dstate words over valid/ready and writes      |
// |            them into a 2*NUM_CELL-entry RAM as two banks of NUM_CELL     |
// |            words. A bank is flagged full when its last word lands and    |
// |            is freed by the consumer's release pulse. Writes stall while  |
// |            the target bank is still held.                                |
// | Ports    : clk, rst          clock, asynchronous active-high reset       |
// |            i_start          begin a run (honoured only in IDLE)          |
// |            i_valid/i_data   producer word + qualifier                    |
// |            i_release        consumer frees the oldest full bank          |
// |            o_ready          word accepted when i_valid && o_ready        |
// |            o_we/o_addr_wr/o_data_wr  registered RAM write port           |
// |            o_full[1:0]      per-bank full flags                          |
// |            o_busy/o_done    run in progress / end-of-run pulse           |
// |            o_err            sticky protocol error                        |
// | Options  : DSTATE_WR_ERRCHK_EN - when defined, protocol violations set   |
// |            o_err and abort the run to IDLE; otherwise o_err stays 0.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dstate_wr_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int NUM_CELL     = 8,
  parameter int NUM_TIMESTEP = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_release,
  output logic                  o_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr_wr,
  output logic [DATA_WIDTH-1:0] o_data_wr,
  output logic [1:0]            o_full,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int IDX_W  = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
  localparam int STEP_W = (NUM_TIMESTEP > 1) ? $clog2(NUM_TIMESTEP) : 1;

  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_CELL - 1);
  localparam logic [STEP_W-1:0]     LAST_STEP  = STEP_W'(NUM_TIMESTEP - 1);
  localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(NUM_CELL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state;
  logic                wr_bank;
  logic                rd_bank;
  logic [IDX_W-1:0]    idx;
  logic [STEP_W-1:0]   step;
  logic [1:0]          full;

  logic                accept;
  logic                bank_done;
  logic                rel_hit;
  logic [1:0]          full_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                err_event;

  assign o_ready = (state == ST_FILL) && !full[wr_bank];
  assign o_busy  = (state != ST_IDLE);
  assign o_full  = full;

  // Release is judged against the current flags, so a bank that completes
  // this cycle can never be the one being released. full_nxt is the
  // post-release, post-complete view used for the WAIT/DONE decisions.
  always_comb begin
    accept    = o_ready && i_valid;
    bank_done = accept && (idx == LAST_IDX);
    rel_hit   = i_release && full[rd_bank];
    full_nxt  = full;
    if (rel_hit)   full_nxt[rd_bank] = 1'b0;
    if (bank_done) full_nxt[wr_bank] = 1'b1;
    wr_addr   = (wr_bank ? BANK1_BASE : '0) + ADDR_WIDTH'(idx);
  end

`ifdef DSTATE_WR_ERRCHK_EN
  // Producer pushing into a stalled buffer, or a release with nothing held.
  assign err_event = (((state == ST_FILL) || (state == ST_WAIT)) && i_valid && !o_ready)
                   || (i_release && (full == 2'b00));
`else
  assign err_event = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      idx       <= '0;
      step      <= '0;
      full      <= 2'b00;
      o_we      <= 1'b0;
      o_addr_wr <= '0;
      o_data_wr <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (err_event) begin
        // Abort: drop all progress, including flags, so a new run starts clean.
        o_err   <= 1'b1;
        state   <= ST_IDLE;
        wr_bank <= 1'b0;
        rd_bank <= 1'b0;
        idx     <= '0;
        step    <= '0;
        full    <= 2'b00;
        o_we    <= 1'b0;
      end else begin
        o_we <= accept;
        if (accept) begin
          o_addr_wr <= wr_addr;
          o_data_wr <= i_data;
          if (bank_done) begin
            idx     <= '0;
            wr_bank <= ~wr_bank;
            step    <= step + STEP_W'(1);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        full <= full_nxt;
        if (rel_hit) rd_bank <= ~rd_bank;

        case (state)
          ST_IDLE: begin
            if (i_start) begin
              state   <= ST_FILL;
              idx     <= '0;
              step    <= '0;
              wr_bank <= 1'b0;
              rd_bank <= 1'b0;
            end
          end
          ST_FILL: begin
            if (bank_done) begin
              if (step == LAST_STEP)
                state <= ST_DONE;
              else if (full_nxt[~wr_bank])
                state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            // Uses post-release flags so a release resumes writes next cycle.
            if (!full_nxt[wr_bank]) state <= ST_FILL;
          end
          ST_DONE: begin
            if (full_nxt == 2'b00) begin
              o_done <= 1'b1;
              state  <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dstate_wr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dstate_wr_ctrl                                             |
// | Purpose  : Directed self-checking bench for dstate_wr_ctrl               |
// |            (NUM_CELL=8, NUM_TIMESTEP=3). Honours DSTATE_WR_ERRCHK_EN.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dstate_wr_ctrl;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          valid;
  logic [DW-1:0] data;
  logic          release_p;
  logic          ready;
  logic          we;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] data_wr;
  logic [1:0]    full;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;

  dstate_wr_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_CELL    (8),
    .NUM_TIMESTEP(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (start),
    .i_valid  (valid),
    .i_data   (data),
    .i_release(release_p),
    .o_ready  (ready),
    .o_we     (we),
    .o_addr_wr(addr_wr),
    .o_data_wr(data_wr),
    .o_full   (full),
    .o_busy   (busy),
    .o_done   (done),
    .o_err    (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted word: drives valid/data (and optionally release) for one edge,
  // then checks the registered write port. valid is left high afterwards.
  task automatic write_word(input int exp_addr, input logic rel);
    logic [DW-1:0] w;
    w         = DW'(16'h1000 + exp_addr * 3 + checks);
    valid     = 1'b1;
    data      = w;
    release_p = rel;
    tick();
    release_p = 1'b0;
    check_val("we", 32'(we), 32'd1);
    check_val("addr", 32'(addr_wr), 32'(exp_addr));
    check_val("data", 32'(data_wr), 32'(w));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; release_p = 1'b0;
    tick(); tick();
    // Reset state
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_we",    32'(we),    32'd0);
    check_val("rst_addr",  32'(addr_wr), 32'd0);
    check_val("rst_data",  32'(data_wr), 32'd0);
    check_val("rst_full",  32'(full),  32'd0);
    check_val("rst_busy",  32'(busy),  32'd0);
    check_val("rst_done",  32'(done),  32'd0);
    check_val("rst_err",   32'(err),   32'd0);
    rst = 1'b0;
    tick();

    // ---- Basic fill: 16 back-to-back words, no release ----
    start = 1'b1; tick(); start = 1'b0;
    check_val("start_ready", 32'(ready), 32'd1);
    check_val("start_busy",  32'(busy),  32'd1);
    for (int k = 0; k < 16; k++) begin
      write_word(k, 1'b0);
      if (k == 7) begin
        check_val("fill_full01", 32'(full), 32'b01);
        check_val("fill_nobubble", 32'(ready), 32'd1);
      end
    end
    check_val("fill_full11", 32'(full), 32'b11);
    check_val("fill_stall", 32'(ready), 32'd0);

    // ---- Stall and resume ----
`ifdef DSTATE_WR_ERRCHK_EN
    valid = 1'b0;
`endif
    release_p = 1'b1; tick(); release_p = 1'b0;
    check_val("resume_full", 32'(full), 32'b10);
    check_val("resume_ready", 32'(ready), 32'd1);
    check_val("resume_we", 32'(we), 32'd0);
    // Third bank (last step) into bank 0
    for (int k = 0; k < 8; k++) write_word(k, 1'b0);
    valid = 1'b0;
    check_val("done_state_ready", 32'(ready), 32'd0);
    check_val("done_state_full", 32'(full), 32'b11);
    check_val("done_state_busy", 32'(busy), 32'd1);

    // ---- Run completion: release both banks ----
    release_p = 1'b1; tick(); release_p = 1'b0;
    check_val("rel1_full", 32'(full), 32'b01);
    check_val("rel1_done", 32'(done), 32'd0);
    release_p = 1'b1; tick(); release_p = 1'b0;
    check_val("rel2_full", 32'(full), 32'b00);
    check_val("rel2_done", 32'(done), 32'd1);
    check_val("rel2_busy", 32'(busy), 32'd0);
    tick();
    check_val("done_pulse", 32'(done), 32'd0);

    // ---- Simultaneous bank-complete and release ----
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) write_word(k, 1'b0);
    check_val("sim_full01", 32'(full), 32'b01);
    for (int k = 8; k < 15; k++) write_word(k, 1'b0);
    write_word(15, 1'b1);
    check_val("sim_full10", 32'(full), 32'b10);
    check_val("sim_ready", 32'(ready), 32'd1);
    write_word(0, 1'b0);
    for (int k = 1; k < 5; k++) write_word(k, 1'b0);

    // ---- Asynchronous reset mid-run ----
    rst = 1'b1;
    #1;
    check_val("arst_we",    32'(we),      32'd0);
    check_val("arst_addr",  32'(addr_wr), 32'd0);
    check_val("arst_data",  32'(data_wr), 32'd0);
    check_val("arst_full",  32'(full),    32'd0);
    check_val("arst_ready", 32'(ready),   32'd0);
    check_val("arst_busy",  32'(busy),    32'd0);
    valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    write_word(0, 1'b0);
    valid = 1'b0;

    // ---- Release with nothing held, from IDLE ----
    rst = 1'b1; tick(); rst = 1'b0; tick();
    release_p = 1'b1; tick(); release_p = 1'b0;
`ifdef DSTATE_WR_ERRCHK_EN
    check_val("err_set", 32'(err), 32'd1);
    tick(); tick();
    check_val("err_sticky", 32'(err), 32'd1);
`else
    check_val("err_clear", 32'(err), 32'd0);
    tick();
    check_val("err_still_clear", 32'(err), 32'd0);
`endif
    check_val("err_busy", 32'(busy), 32'd0);
    check_val("err_full", 32'(full), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
